truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequential controller that exhaustively exercises a 5-input combinational function block (X4..X0 -> F) in hardware.
- Steps the input vector through every code 0..31 and waits a programmable settle time per vector.
- Samples F and assembles the captured truth table, a ones count and a pass/fail compare against an expected table.
- Sits between a test harness or host register interface and the function-under-test instance. It replaces the open-loop stimulus loop with a self-checking, restartable sweep.

Parameters:
- N_IN, 5, number of function inputs; number of vectors N_VEC = 2**N_IN.
- SETTLE, 1, cycles the vector is held before F is sampled; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress.
- f_in  input  1  output F of the function under test.
- expected  input  N_VEC  golden truth table; bit i = expected F for vector i.
- x_out  output  N_IN  vector driven to the function inputs; x_out[4] = X4 ... x_out[0] = X0.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  N_VEC  captured truth table; bit i = F sampled for vector i.
- ones_cnt  output  N_IN+1  number of vectors with F = 1 (range 0..32).
- match  output  1  table_out == expected, evaluated at completion.

Behaviour:
- Reset:
  - Applied at any clk edge where rst = 1, including mid-sweep.
  - Forces state IDLE, x_out = 0, busy = 0, done = 0, table_out = 0, ones_cnt = 0, match = 0, settle counter = 0.
  - rst takes priority over start and abort.
- All outputs are registered; none is combinational from inputs.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy = 0.
  - When start = 1, the next state is SETTLE. On that same edge: x_out = 0, index = 0, table_out = 0, ones_cnt = 0, match = 0, settle counter = 0, busy = 1.
- SETTLE:
  - Holds x_out and increments the settle counter.
  - When the counter reaches SETTLE-1, the next state is SAMPLE.
- SAMPLE (one cycle):
  - table_out[index] = f_in.
  - ones_cnt = ones_cnt + f_in.
  - If index == N_VEC-1:
    - match = (table_out with bit index replaced by f_in) == expected.
    - Next state is DONE.
  - Otherwise:
    - index and x_out increment by 1, the settle counter clears, and the next state is SETTLE.
- DONE (one cycle):
  - done = 1 and busy = 0 in this cycle.
  - Unconditionally returns to IDLE; done falls the following cycle.
  - start during DONE is ignored.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done is high in the cycle beginning N_VEC*(SETTLE+1) edges after the edge that accepted start (64 edges with the defaults).
  - F is sampled after x_out has been stable for SETTLE full cycles.
- Result retention: table_out, ones_cnt and match hold their values after DONE until the next accepted start or rst.
- start while busy is ignored and has no effect on the index or the captured data.
- abort:
  - In SETTLE or SAMPLE, the next state is IDLE. busy = 0, no done pulse, match = 0.
  - table_out and ones_cnt keep their partial contents; x_out holds its value.
  - abort has priority over the SAMPLE capture in the same cycle.
  - abort in IDLE or DONE has no effect.
- Width rules:
  - index is N_IN bits and never wraps, because the last vector is detected explicitly.
  - ones_cnt is N_IN+1 bits, so a count of 32 is representable without overflow.
- expected is sampled only at the final SAMPLE; changes at other times do not matter.

Test Plan:
- Reset: assert rst mid-sweep at vector 10 -> next cycle all outputs 0, state IDLE; a later start runs a full sweep normally.
- Identity bit: f_in = x_out[0], expected = 32'hAAAAAAAA, pulse start -> done exactly 64 edges later; table_out = 32'hAAAAAAAA, ones_cnt = 16, match = 1; x_out visits 0..31 in order, each held 2 cycles.
- Mismatch: f_in = x_out[4] & x_out[3], expected = 32'hFF000000 -> table_out = 32'hFF000000, ones_cnt = 8, match = 1. Repeat with expected = 32'hFF000001 -> match = 0, with table_out and ones_cnt unchanged.
- Constant inputs: f_in tied to 1 -> ones_cnt = 32, table_out = 32'hFFFFFFFF. Tied to 0 -> ones_cnt = 0.
- start while busy: pulse start again at vector 5 -> no restart, done still at edge 64. Back-to-back: start asserted in the DONE cycle is ignored; start in the following IDLE cycle clears table_out and ones_cnt and begins a new sweep.
- Abort: pulse abort during the SAMPLE of vector 7 with f_in = 1 -> busy = 0 next cycle, no done pulse, bit 7 not written, ones_cnt = 7, x_out = 7. Parameter variant SETTLE = 3 -> done 128 edges after start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 5-input function through all codes, captures F and checks it against a golden table.
module truth_table_sweeper #(
  parameter int N_IN = 5,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_in,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      x_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_cnt,
  output logic                 match
);
  localparam int N_VEC = 2**N_IN;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t r_state, w_next;
  logic [N_IN-1:0]  r_x;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_match;
  logic [N_VEC-1:0] r_tbl, w_tbl;
  logic [N_IN:0]    r_ones;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_SETTLE : S_IDLE;
      S_SETTLE: w_next = abort ? S_IDLE : (r_cnt == CW'(SETTLE - 1)) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: w_next = abort ? S_IDLE : (&r_x) ? S_DONE : S_SETTLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // x_out doubles as the vector index; the last vector is caught by &r_x so it never wraps
  always_comb begin
    w_tbl = r_tbl;
    w_tbl[r_x] = f_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tbl   <= '0;
      r_ones  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_x     <= '0;
          r_cnt   <= '0;
          r_tbl   <= '0;
          r_ones  <= '0;
          r_match <= 1'b0;
          r_busy  <= 1'b1;
        end
        S_SETTLE: if (abort) r_busy <= 1'b0; else r_cnt <= r_cnt + 1'b1;
        S_SAMPLE: if (abort) r_busy <= 1'b0; else begin
          r_tbl  <= w_tbl;
          r_ones <= r_ones + {{N_IN{1'b0}}, f_in};
          r_cnt  <= '0;
          if (&r_x) begin
            r_match <= (w_tbl == expected);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else r_x <= r_x + 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign x_out     = r_x;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_tbl;
  assign ones_cnt  = r_ones;
  assign match     = r_match;
endmodule
